// File: rtl/track_recorder.sv
// Rhythm-game track recorder. It clears a 32x4 track RAM, then records one
// OR-accumulated note word per beat slot. Every output comes straight from a flop.
module track_recorder #(
  parameter int TRACK_LEN = 32
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       abort,
  input  logic       beat_tick,
  input  logic [3:0] notes_in,
  output logic [4:0] ram_address,
  output logic [3:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RECORD,
    S_DONE
  } state_e;

  localparam logic [4:0] LAST_SLOT = 5'(TRACK_LEN - 1);

  state_e     state_q;
  logic [4:0] addr_q;
  logic [3:0] data_q;
  logic       wren_q;
  logic       busy_q;
  logic       done_q;
  logic [4:0] slot_q;
  logic [3:0] acc_q;

  // NOTE: state and outputs share one clocked block with non-blocking
  // assignments, so every output is a registered copy of the decision.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      slot_q  <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          wren_q <= 1'b0;
          // The first clear write goes out on the cycle right after start.
          if (start) begin
            state_q <= S_CLEAR;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            slot_q  <= '0;
            acc_q   <= '0;
          end
        end

        S_CLEAR: begin
          if (abort) begin
            state_q <= S_IDLE;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (addr_q == LAST_SLOT) begin
            state_q <= S_RECORD;
            wren_q  <= 1'b0;
            slot_q  <= '0;
            acc_q   <= '0;
          end else begin
            addr_q <= addr_q + 5'd1;
            wren_q <= 1'b1;
          end
        end

        S_RECORD: begin
          if (abort) begin
            state_q <= S_IDLE;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            slot_q  <= '0;
            acc_q   <= '0;
          end else if (beat_tick) begin
            // Notes on the tick cycle belong to the slot being closed.
            wren_q <= 1'b1;
            addr_q <= slot_q;
            data_q <= acc_q | notes_in;
            acc_q  <= '0;
            if (slot_q == LAST_SLOT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              slot_q  <= '0;
            end else begin
              slot_q <= slot_q + 5'd1;
            end
          end else begin
            wren_q <= 1'b0;
            acc_q  <= acc_q | notes_in;
          end
        end

        default: begin
          state_q <= S_IDLE;
          wren_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/track_recorder.md
TRACK_RECORDER -- requirements
Module: track_recorder

Interface
REQ-001 Parameter TRACK_LEN, default 32: number of beat slots recorded; legal range 1..32.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to clear the track RAM and begin recording.
REQ-005 abort  input  1  single-cycle request to stop immediately and return to idle.
REQ-006 beat_tick  input  1  single-cycle pulse marking the end of one beat slot.
REQ-007 notes_in  input  4  per-lane note buttons, active-high, one bit per lane.
REQ-008 ram_address  output  5  write address to the 32x4 track RAM.
REQ-009 ram_data  output  4  write data to the track RAM.
REQ-010 ram_wren  output  1  write enable to the track RAM; one write per asserted cycle.
REQ-011 busy  output  1  high while clearing or recording.
REQ-012 done  output  1  high after a full recording completes, until next start or reset.

Function
REQ-013 All outputs SHALL be registered; states are IDLE, CLEAR, RECORD, DONE.
REQ-014 IDLE: ram_wren=0, busy=0, done=0; start=1 -> CLEAR with address counter 0.
REQ-015 CLEAR: each cycle ram_wren=1, ram_data=0000, ram_address=0,1,...,TRACK_LEN-1 on consecutive cycles; after writing TRACK_LEN-1 -> RECORD with address counter 0.
REQ-016 CLEAR SHALL take exactly TRACK_LEN cycles of ram_wren=1; beat_tick and notes_in are ignored in CLEAR.
REQ-017 RECORD: a 4-bit accumulator SHALL OR in notes_in every cycle; accumulator is 0 on RECORD entry.
REQ-018 beat_tick sampled 1 at cycle N in RECORD -> at cycle N+1 ram_wren=1, ram_address=current slot, ram_data=accumulator|notes_in(N).
REQ-019 On that write the accumulator SHALL restart from 0 (notes at N are not carried into the next slot) and the slot counter SHALL increment.
REQ-020 ram_wren SHALL be 0 in RECORD on all cycles not following a beat_tick.
REQ-021 After the write for slot TRACK_LEN-1 -> DONE; no address beyond TRACK_LEN-1 is ever written (no wrap-around).
REQ-022 DONE: ram_wren=0, busy=0, done=1; start=1 -> CLEAR (done drops the next cycle).
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 abort=1 in CLEAR or RECORD -> IDLE next cycle, no further writes, partially written slots left as-is; abort has priority over beat_tick and start in the same cycle.
REQ-025 abort in IDLE or DONE SHALL be ignored.
REQ-026 ram_address SHALL hold its last value when ram_wren=0.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, ram_address=0, ram_data=0, ram_wren=0, busy=0, done=0, accumulator and counters 0, regardless of clock.
REQ-028 Reset mid-CLEAR or mid-RECORD SHALL abandon the operation; the first write after release requires a new start.

Verification
REQ-029 Reset then start pulse -> exactly 32 consecutive cycles ram_wren=1, data 0000, addresses 0..31, busy=1, then RECORD.
REQ-030 In RECORD: notes_in=0001 for 3 cycles, 0100 on tick cycle -> one write, address 0, data 0101; next slot's accumulator starts 0.
REQ-031 32 beat_ticks with no notes -> writes to addresses 0..31 data 0000, then done=1, busy=0, no 33rd write.
REQ-032 abort coincident with beat_tick at slot 5 -> no write, IDLE next cycle, busy=0, done=0.
REQ-033 start asserted during CLEAR -> ignored, clear sequence unchanged; start in DONE -> new 32-cycle clear.
REQ-034 resetn pulsed low asynchronously mid-RECORD -> ram_wren, busy, done 0 immediately; no writes until next start.
